key_press_gen: RTL and testbench

Synthesizable key-press stimulus generator: the transmitting end of the board's key-debounce/edge-detect path. On a handshaked request it drives one line of an active-low 4-key bus through a scripted press: contact bounce, stable hold, release bounce, then an idle gap. It sits in self-test builds in place of the physical buttons and feeds the key-debounce receiver, so LED-toggle logic can be exercised on hardware and in simulation without human input.

---
 rtl/key_press_gen_pkg.sv | 26 ++
 rtl/key_phase_timer.sv | 37 +++
 rtl/key_press_gen.sv | 184 ++++++++++++++++++
 tb/tb_key_press_gen.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_press_gen_pkg.sv
// Shared types and 50 MHz defaults for the key-press stimulus generator.
package key_press_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_B,
    ST_HOLD,
    ST_REL_B,
    ST_GAP
  } state_e;

  localparam int unsigned DEF_BOUNCE_CYC   = 50_000;
  localparam int unsigned DEF_GAP_CYC      = 1_500_000;
  localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;

  localparam logic [3:0] KEY_IDLE = 4'b1111;

  // Idle bus with only the selected line driven; low=1 pulls it to 0.
  function automatic logic [3:0] key_drive(input logic [1:0] sel, input logic low);
    logic [3:0] k;
    k      = KEY_IDLE;
    k[sel] = ~low;
    return k;
  endfunction

endpackage

// File: rtl/key_phase_timer.sv
// Loadable phase down-counter; tc is high while the count is zero.
// Ports: clk, rstn (async active-low), load/load_val, cnt, tc.
module key_phase_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == '0);

endmodule

// File: rtl/key_press_gen.sv
// Scripted key-press generator: on an accepted request drives one line of an
// active-low 4-key bus through press bounce, hold, release bounce and an idle gap.
// Ports: req_valid/req_ready/req_key/req_hold request handshake, abort,
// key (registered active-low bus), busy, done (one-cycle end pulse).
module key_press_gen
  import key_press_gen_pkg::*;
#(
  parameter int unsigned BOUNCE_CYC = DEF_BOUNCE_CYC,
  parameter int unsigned BOUNCE_N   = 3,
  parameter int unsigned GAP_CYC    = DEF_GAP_CYC,
  parameter int unsigned CNT_W      = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_key,
  input  logic [CNT_W-1:0] req_hold,
  input  logic             abort,
  output logic [3:0]       key,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      PH_W      = (BOUNCE_N > 1) ? $clog2(2 * BOUNCE_N) : 1;
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * BOUNCE_N - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LD = CNT_W'(BOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC - 1);

  if (BOUNCE_CYC < 1 || 64'(BOUNCE_CYC) > (64'd1 << CNT_W)) begin : g_bad_bounce_cyc
    $error("key_press_gen: BOUNCE_CYC out of range for CNT_W");
  end
  if (GAP_CYC < 1 || 64'(GAP_CYC) > (64'd1 << CNT_W)) begin : g_bad_gap_cyc
    $error("key_press_gen: GAP_CYC out of range for CNT_W");
  end

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [3:0]       key_q, key_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             ld;
  logic [CNT_W-1:0] ld_val;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic [CNT_W-1:0] hold_m1;

  key_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (ld),
    .load_val (ld_val),
    .cnt      (cnt),
    .tc       (tc)
  );

  assign hold_m1   = (req_hold == '0) ? '0 : req_hold - CNT_W'(1);
  assign req_ready = (state_q == ST_IDLE) && !abort;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    key_d   = key_q;
    ld      = 1'b0;
    ld_val  = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          sel_d   = req_key;
          hold_d  = hold_m1;
          phase_d = '0;
          key_d   = key_drive(req_key, 1'b1);
          ld      = 1'b1;
          if (BOUNCE_N == 0) begin
            state_d = ST_HOLD;
            ld_val  = hold_m1;
          end else begin
            state_d = ST_PRESS_B;
            ld_val  = BOUNCE_LD;
          end
        end
      end

      ST_PRESS_B, ST_HOLD, ST_REL_B: begin
        if (abort) begin
          state_d = ST_GAP;
          phase_d = '0;
          key_d   = KEY_IDLE;
          ld      = 1'b1;
          ld_val  = GAP_LD;
        end else if (tc) begin
          ld = 1'b1;
          if (state_q == ST_PRESS_B) begin
            if (phase_q == PH_LAST) begin
              state_d = ST_HOLD;
              phase_d = '0;
              key_d   = key_drive(sel_q, 1'b1);
              ld_val  = hold_q;
            end else begin
              // Press bounce: even phases low, odd phases high.
              phase_d = phase_q + PH_W'(1);
              key_d   = key_drive(sel_q, ~phase_d[0]);
              ld_val  = BOUNCE_LD;
            end
          end else if (state_q == ST_HOLD) begin
            if (BOUNCE_N == 0) begin
              state_d = ST_GAP;
              key_d   = KEY_IDLE;
              ld_val  = GAP_LD;
            end else begin
              state_d = ST_REL_B;
              phase_d = '0;
              key_d   = KEY_IDLE;
              ld_val  = BOUNCE_LD;
            end
          end else begin
            if (phase_q == PH_LAST) begin
              state_d = ST_GAP;
              phase_d = '0;
              key_d   = KEY_IDLE;
              ld_val  = GAP_LD;
            end else begin
              // Release bounce: even phases high, odd phases low.
              phase_d = phase_q + PH_W'(1);
              key_d   = key_drive(sel_q, phase_d[0]);
              ld_val  = BOUNCE_LD;
            end
          end
        end
      end

      ST_GAP: begin
        if (tc) begin
          state_d = ST_IDLE;
          key_d   = KEY_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        key_d   = KEY_IDLE;
      end
    endcase

    // done is registered, so it is asserted one cycle ahead: entering the
    // final GAP cycle either via a load of 0 or by counting down to 0.
    done_d = (state_d == ST_GAP) && (ld ? (ld_val == '0) : (cnt == CNT_W'(1)));
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      sel_q   <= '0;
      hold_q  <= '0;
      key_q   <= KEY_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign key  = key_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_key_press_gen.sv
// Bench for key_press_gen: table of press requests with expected done cycle,
// per-cycle scoreboard of expected bus/status, plus hand-written multi-cycle cases.
module tb_key_press_gen;

  localparam int unsigned BC  = 4;
  localparam int unsigned BN  = 2;
  localparam int unsigned GC  = 10;
  localparam int unsigned CW  = 24;
  localparam int unsigned WIN = 6;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;

  logic          a_req_valid = 1'b0, a_abort = 1'b0;
  logic [1:0]    a_req_key   = '0;
  logic [CW-1:0] a_req_hold  = '0;
  logic          a_req_ready, a_busy, a_done;
  logic [3:0]    a_key;

  logic          b_req_valid = 1'b0, b_abort = 1'b0;
  logic [1:0]    b_req_key   = '0;
  logic [CW-1:0] b_req_hold  = '0;
  logic          b_req_ready, b_busy, b_done;
  logic [3:0]    b_key;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  key_press_gen #(
    .BOUNCE_CYC (BC),
    .BOUNCE_N   (BN),
    .GAP_CYC    (GC),
    .CNT_W      (CW)
  ) u_dut_a (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_key   (a_req_key),
    .req_hold  (a_req_hold),
    .abort     (a_abort),
    .key       (a_key),
    .busy      (a_busy),
    .done      (a_done)
  );

  key_press_gen #(
    .BOUNCE_CYC (BC),
    .BOUNCE_N   (0),
    .GAP_CYC    (GC),
    .CNT_W      (CW)
  ) u_dut_b (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_key   (b_req_key),
    .req_hold  (b_req_hold),
    .abort     (b_abort),
    .key       (b_key),
    .busy      (b_busy),
    .done      (b_done)
  );

  // Simple debounce receiver on DUT A: a line change is taken once it has been
  // stable for WIN cycles; each debounced fall toggles that line's LED.
  logic [3:0] db_q;
  logic [3:0] led;
  int         stab     [4];
  int         fall_cnt [4];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_q <= '1;
      led  <= '0;
      for (int k = 0; k < 4; k++) begin
        stab[k]     <= 0;
        fall_cnt[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (a_key[k] == db_q[k]) begin
          stab[k] <= 0;
        end else if (stab[k] == int'(WIN) - 1) begin
          db_q[k] <= a_key[k];
          stab[k] <= 0;
          if (!a_key[k]) begin
            fall_cnt[k] <= fall_cnt[k] + 1;
            led[k]      <= ~led[k];
          end
        end else begin
          stab[k] <= stab[k] + 1;
        end
      end
    end
  end

  typedef struct {
    logic [3:0] key;
    logic       done;
    logic       busy;
    logic       ready;
  } exp_t;

  typedef struct {
    int         sel;
    logic [1:0] key;
    int         hold;
    int         abort_cyc;
    int         exp_done;
  } vec_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic v, input logic [1:0] k, input logic [CW-1:0] h);
    if (sel == 0) begin
      a_req_valid = v; a_req_key = k; a_req_hold = h;
    end else begin
      b_req_valid = v; b_req_key = k; b_req_hold = h;
    end
  endtask

  task automatic set_abort(input int sel, input logic v);
    if (sel == 0) a_abort = v;
    else          b_abort = v;
  endtask

  task automatic sample(input int sel, output logic [3:0] k, output logic d,
                        output logic b, output logic r);
    if (sel == 0) begin
      k = a_key; d = a_done; b = a_busy; r = a_req_ready;
    end else begin
      k = b_key; d = b_done; b = b_busy; r = b_req_ready;
    end
  endtask

  // Entered just after a rising edge (cycle 0); accepts on the edge ending cycle 0.
  task automatic run_press(input vec_t v, input int idx);
    int         n, h, len, cyc, done_cyc;
    logic       low_seq[$];
    logic [3:0] mask;
    logic [3:0] k;
    logic       d, b, r;
    exp_t       e;

    n    = (v.sel == 0) ? int'(BN) : 0;
    h    = (v.hold == 0) ? 1 : v.hold;
    mask = 4'hF;
    mask[v.key] = 1'b0;

    for (int p = 0; p < 2 * n; p++)
      for (int j = 0; j < int'(BC); j++) low_seq.push_back(p % 2 == 0);
    for (int j = 0; j < h; j++) low_seq.push_back(1'b1);
    for (int p = 0; p < 2 * n; p++)
      for (int j = 0; j < int'(BC); j++) low_seq.push_back(p % 2 == 1);
    if (v.abort_cyc > 0)
      while (low_seq.size() > v.abort_cyc) void'(low_seq.pop_back());
    for (int j = 0; j < int'(GC); j++) low_seq.push_back(1'b0);

    len = low_seq.size();
    for (int c = 0; c < len; c++) begin
      e.key   = low_seq[c] ? mask : 4'hF;
      e.done  = (c == len - 1);
      e.busy  = 1'b1;
      e.ready = 1'b0;
      sb_q.push_back(e);
    end
    e.key = 4'hF; e.done = 1'b0; e.busy = 1'b0; e.ready = 1'b1;
    sb_q.push_back(e);

    set_req(v.sel, 1'b1, v.key, CW'(v.hold));
    @(negedge clk);
    sample(v.sel, k, d, b, r);
    check($sformatf("v%0d_ready_c0", idx), 32'(r), 32'd1);
    @(posedge clk); #1;
    set_req(v.sel, 1'b0, 2'd0, '0);

    cyc      = 1;
    done_cyc = -1;
    while (sb_q.size() > 0) begin
      set_abort(v.sel, cyc == v.abort_cyc);
      @(negedge clk);
      sample(v.sel, k, d, b, r);
      e = sb_q.pop_front();
      check($sformatf("v%0d_c%0d_key", idx, cyc), 32'(k), 32'(e.key));
      check($sformatf("v%0d_c%0d_done", idx, cyc), 32'(d), 32'(e.done));
      check($sformatf("v%0d_c%0d_busy", idx, cyc), 32'(b), 32'(e.busy));
      check($sformatf("v%0d_c%0d_ready", idx, cyc), 32'(r), 32'(e.ready));
      if (d && done_cyc < 0) done_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    set_abort(v.sel, 1'b0);
    check($sformatf("v%0d_done_cycle", idx), 32'(done_cyc), 32'(v.exp_done));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[9];
    int   dc;
    logic ok;

    vt[0] = '{0, 2'd1, 20, -1, 62};  // basic press
    vt[1] = '{1, 2'd3,  0, -1, 11};  // no bounce, hold 0 treated as 1
    vt[2] = '{0, 2'd1, 20, 20, 30};  // abort in HOLD
    vt[3] = '{0, 2'd0,  0, -1, 43};  // hold 0 with bounce
    vt[4] = '{0, 2'd2,  5,  3, 13};  // abort in PRESS_B
    vt[5] = '{0, 2'd3,  7, 30, 40};  // abort in REL_B
    vt[6] = '{0, 2'd2,  1,  1, 11};  // abort on first cycle
    vt[7] = '{0, 2'd1, 20, 55, 62};  // abort in GAP ignored
    vt[8] = '{1, 2'd1,  5,  3, 13};  // abort in HOLD, no bounce

    repeat (3) @(posedge clk);
    #1;
    check("rst_key_a", 32'(a_key), 32'hF);
    check("rst_busy_a", 32'(a_busy), 32'd0);
    check("rst_done_a", 32'(a_done), 32'd0);
    check("rst_key_b", 32'(b_key), 32'hF);
    #2 rstn = 1'b1;
    @(negedge clk);
    check("post_rst_ready_a", 32'(a_req_ready), 32'd1);
    check("post_rst_ready_b", 32'(b_req_ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_press(vt[i], i);
      if (i == 0) begin
        check("loop_fall_cnt_k1", 32'(fall_cnt[1]), 32'd1);
        check("loop_led", 32'(led), 32'b0010);
      end
    end

    // abort held in IDLE masks req_ready and blocks accept
    a_abort = 1'b1;
    set_req(0, 1'b1, 2'd0, CW'(3));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("idle_abort_ready_c%0d", c), 32'(a_req_ready), 32'd0);
      @(posedge clk); #1;
      check($sformatf("idle_abort_busy_c%0d", c), 32'(a_busy), 32'd0);
      check($sformatf("idle_abort_key_c%0d", c), 32'(a_key), 32'hF);
    end
    set_req(0, 1'b0, 2'd0, '0);
    a_abort = 1'b0;
    @(posedge clk); #1;

    // back-to-back: key 0 then key 2, req_valid held high
    set_req(0, 1'b1, 2'd0, CW'(20));
    @(posedge clk); #1;
    set_req(0, 1'b1, 2'd2, CW'(20));
    dc = -1;
    ok = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      if (c == 64) set_req(0, 1'b0, 2'd0, '0);
      @(negedge clk);
      if (c <= 63 && a_key[2] !== 1'b1) ok = 1'b0;
      if (c == 62) check("b2b_first_done", 32'(a_done), 32'd1);
      if (c == 63) begin
        check("b2b_ready_63", 32'(a_req_ready), 32'd1);
        check("b2b_key_63", 32'(a_key), 32'hF);
        check("b2b_busy_63", 32'(a_busy), 32'd0);
      end
      if (c == 64) begin
        check("b2b_key_64", 32'(a_key), 32'b1011);
        check("b2b_busy_64", 32'(a_busy), 32'd1);
      end
      if (c > 63 && a_done) begin
        dc = c;
        break;
      end
      @(posedge clk); #1;
    end
    check("b2b_no_overlap", 32'(ok), 32'd1);
    check("b2b_second_done", 32'(dc), 32'd125);
    @(posedge clk); #1;

    // asynchronous reset in the middle of a press, request left pending
    set_req(0, 1'b1, 2'd1, CW'(20));
    @(posedge clk); #1;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
    end
    check("rst_mid_pre_key", 32'(a_key), 32'b1101);
    #1 rstn = 1'b0;
    #1;
    check("rst_mid_key", 32'(a_key), 32'hF);
    check("rst_mid_busy", 32'(a_busy), 32'd0);
    check("rst_mid_done", 32'(a_done), 32'd0);
    #1 rstn = 1'b1;
    #1;
    check("rst_mid_ready", 32'(a_req_ready), 32'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 2'd0, '0);
    check("rst_reaccept_key", 32'(a_key), 32'b1101);
    check("rst_reaccept_busy", 32'(a_busy), 32'd1);
    dc = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (a_done) begin
        dc = c;
        break;
      end
      @(posedge clk); #1;
    end
    check("rst_reaccept_done", 32'(dc), 32'd62);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
